aes128_ecb_decryptor_iter: RTL and testbench
============================================

// Module: aes128_ecb_decryptor_iter
// PURPOSE
//  Iterative AES-128 ECB decryptor, one round per clock. Inverse partner of the
//  AES-128 ECB encrypt top in the same design tree.
//  Takes one 128-bit key plus ciphertext per valid/ready transaction and returns
//  the plaintext on a valid/ready output.
//  Round keys are derived on the fly: a forward expansion produces rk10, then the
//  inverse key schedule steps rk back down to rk0.
// PARAMETERS
//  KEY_REUSE  1  1: if key equals the last fully expanded key, skip expansion (stored rk10)
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst_n        in   1    synchronous reset, active-low
//  in_valid     in   1    key/cipher_text valid
//  in_ready     out  1    block can accept a transaction (high only in IDLE)
//  key          in   128  cipher key, FIPS-197 byte order (byte0 = [127:120])
//  cipher_text  in   128  ciphertext block, same byte order
//  out_valid    out  1    plain_text valid; held until out_ready
//  out_ready    in   1    downstream accepts plain_text
//  plain_text   out  128  decrypted block; stable while out_valid
// BEHAVIOUR
//  Reset: rst_n low at edge -> state IDLE. Outputs: in_ready=1, out_valid=0,
//   plain_text=0. Cached-key flag cleared. Reset overrides everything, including a
//   transaction in progress; that transaction is dropped with no output.
//  FSM: IDLE -> KEXP -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept edge e0 (in_valid&&in_ready) registers key and ct.
//   - Cache hit (KEY_REUSE && cache_vld && key==key_q): state<=ct^rk10_q, go ROUND.
//   - Otherwise: rk<=key, rcon index=1, go KEXP.
//  KEXP: 10 cycles, producing rk1..rk10 (forward schedule with rcon 01,02,..,1b,36).
//   On the 10th edge: rk10 is computed combinationally, state<=ct^rk10,
//   rk10_q<=rk10, key_q<=key, cache_vld<=1; go ROUND.
//  ROUND: rnd counts 9 down to 0; one round per edge.
//   - Each round: rk<=InvKeyStep(rk,rnd+1) = rk_rnd.
//     Word rule: w[i-4]=w[i]^w[i-1] for words 1..3;
//     w0'=w0^SubWord(RotWord(new w3))^rcon[rnd+1].
//   - State update: state <= InvMixColumns(InvSubBytes(InvShiftRows(state))^rk_rnd).
//   - rnd==0: InvMixColumns omitted; plain_text<=result, out_valid<=1, go DONE.
//  Latency from accept edge to out_valid high: 20 cycles on a miss, 10 on a hit.
//  DONE: out_valid=1 and plain_text held. Edge with out_ready -> out_valid=0, IDLE.
//   in_ready stays 0 in DONE, so at most one transaction is in flight.
//  in_valid outside IDLE is ignored; key/cipher_text need only be stable at accept.
//  Back-to-back: earliest next accept is the cycle after the out_ready handshake.
//  All XOR/GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1; no widths are truncated.
// STRUCTURE
//  Package aes128_pkg:
//   - inv_sbox / sbox functions (or ROM tables)
//   - rcon[1:10], xtime/gf_mul
//   - state typedef (4x4 byte array); state_e FSM enum
//   - helpers to_state / from_state for byte-order mapping
//  Sub-module aes128_inv_round (combinational):
//   - state, rk, last -> next_state
//   - FSM, counters and the key-schedule steps stay in this module.
// TESTING
//  1 FIPS-197 C.1: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> pt 00112233445566778899aabbccddeeff; out_valid exactly 20 cycles after accept.
//  2 Same key again, ct 69c4e0d8.. -> same pt; out_valid after 10 cycles (cache hit).
//    With KEY_REUSE=0 this takes 20 cycles.
//  3 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c,
//    ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734 (miss).
//  4 Hold out_ready=0 for 7 cycles after out_valid:
//    -> plain_text stable, in_ready=0, in_valid pulses ignored; release -> IDLE.
//  5 rst_n low during ROUND cycle 5 -> next edge: in_ready=1, out_valid=0, no output.
//    Then rerun test 1: 20-cycle latency, because the cache was cleared.
//  6 Random key/ct stream vs reference model, random out_ready throttling:
//    1000 blocks decrypted correctly, no drops or duplicates.

Source files
------------

// File: rtl/aes128_ecb_decryptor_iter_pkg.sv
// Shared AES-128 types, GF(2^8) arithmetic, S-boxes and key-schedule steps
// for the iterative ECB decryptor.
package aes128_ecb_decryptor_iter_pkg;

  typedef logic [7:0] byte_t;
  // Indexed [row][col]; block byte n sits at row n%4, column n/4.
  typedef logic [3:0][3:0][7:0] aes_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_ROUND, ST_DONE} state_e;

  localparam logic [7:0] GF_POLY = 8'h1b;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires.
  function automatic byte_t gf_inv(input byte_t a);
    byte_t sq;
    byte_t acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic byte_t sbox(input byte_t a);
    byte_t b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(input byte_t s);
    byte_t t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic byte_t rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd_step(input logic [127:0] rk, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon(idx), 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover words 3..1 first, then word 0 from the new word 3.
  function automatic logic [127:0] key_inv_step(input logic [127:0] rk, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rcon(idx), 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic aes_state_t to_state(input logic [127:0] blk);
    aes_state_t s;
    for (int n = 0; n < 16; n++) s[n % 4][n / 4] = blk[8 * (15 - n) +: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input aes_state_t s);
    logic [127:0] blk;
    for (int n = 0; n < 16; n++) blk[8 * (15 - n) +: 8] = s[n % 4][n / 4];
    return blk;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r][c] = s[r][(c + 4 - r) % 4];
    return o;
  endfunction

  function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r][c] = inv_sbox(s[r][c]);
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      o[0][c] = gf_mul(s[0][c], 8'h0e) ^ gf_mul(s[1][c], 8'h0b) ^ gf_mul(s[2][c], 8'h0d) ^ gf_mul(s[3][c], 8'h09);
      o[1][c] = gf_mul(s[0][c], 8'h09) ^ gf_mul(s[1][c], 8'h0e) ^ gf_mul(s[2][c], 8'h0b) ^ gf_mul(s[3][c], 8'h0d);
      o[2][c] = gf_mul(s[0][c], 8'h0d) ^ gf_mul(s[1][c], 8'h09) ^ gf_mul(s[2][c], 8'h0e) ^ gf_mul(s[3][c], 8'h0b);
      o[3][c] = gf_mul(s[0][c], 8'h0b) ^ gf_mul(s[1][c], 8'h0d) ^ gf_mul(s[2][c], 8'h09) ^ gf_mul(s[3][c], 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_ecb_decryptor_iter_if.sv
// Key/ciphertext input handshake and plaintext output handshake of the decryptor.
interface aes128_ecb_decryptor_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] cipher_text;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_text;

  modport master (
    output in_valid, key, cipher_text, out_ready,
    input  in_ready, out_valid, plain_text
  );

  modport slave (
    input  in_valid, key, cipher_text, out_ready,
    output in_ready, out_valid, plain_text
  );
endinterface

// File: rtl/aes128_ecb_decryptor_iter_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes128_ecb_decryptor_iter_inv_round
  import aes128_ecb_decryptor_iter_pkg::*;
(
  input  aes_state_t   i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output aes_state_t   o_state
);

  aes_state_t w_added;

  // Inverse round datapath
  always_comb begin
    w_added = inv_sub_bytes(inv_shift_rows(i_state)) ^ to_state(i_rk);
    if (i_last) begin
      o_state = w_added;
    end else begin
      o_state = inv_mix_columns(w_added);
    end
  end

endmodule

// File: rtl/aes128_ecb_decryptor_iter.sv
// Iterative AES-128 ECB decryptor: forward key expansion to rk10 (skipped when the
// key matches the cached one), then ten inverse rounds walking the schedule back down.
module aes128_ecb_decryptor_iter
  import aes128_ecb_decryptor_iter_pkg::*;
#(
  parameter int KEY_REUSE = 1
) (
  input logic clk,
  input logic rst_n,
  aes128_ecb_decryptor_iter_if.slave bus
);

  state_e       r_fsm;
  logic [127:0] r_rk;
  logic [127:0] r_ct;
  logic [127:0] r_key_in;
  logic [127:0] r_key_q;
  logic [127:0] r_rk10_q;
  logic         r_cache_vld;
  aes_state_t   r_st;
  logic [3:0]   r_rnd;
  logic [3:0]   r_rcon_idx;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_plain;

  logic [127:0] w_rk_fwd;
  logic [127:0] w_rk_inv;
  aes_state_t   w_round_out;
  logic         w_cache_hit;

  assign w_rk_fwd    = key_fwd_step(r_rk, r_rcon_idx);
  assign w_rk_inv    = key_inv_step(r_rk, r_rnd + 4'd1);
  assign w_cache_hit = (KEY_REUSE != 0) && r_cache_vld && (bus.key == r_key_q);

  aes128_ecb_decryptor_iter_inv_round u_inv_round (
    .i_state (r_st),
    .i_rk    (w_rk_inv),
    .i_last  (r_rnd == 4'd0),
    .o_state (w_round_out)
  );

  // Control FSM, key schedule and round state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_rk        <= 128'd0;
      r_ct        <= 128'd0;
      r_key_in    <= 128'd0;
      r_key_q     <= 128'd0;
      r_rk10_q    <= 128'd0;
      r_cache_vld <= 1'b0;
      r_st        <= '0;
      r_rnd       <= 4'd0;
      r_rcon_idx  <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_plain     <= 128'd0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_ct       <= bus.cipher_text;
            r_key_in   <= bus.key;
            r_in_ready <= 1'b0;
            if (w_cache_hit) begin
              r_st  <= to_state(bus.cipher_text ^ r_rk10_q);
              r_rk  <= r_rk10_q;
              r_rnd <= 4'd9;
              r_fsm <= ST_ROUND;
            end else begin
              r_rk       <= bus.key;
              r_rcon_idx <= 4'd1;
              r_fsm      <= ST_KEXP;
            end
          end
        end
        ST_KEXP: begin
          r_rk       <= w_rk_fwd;
          r_rcon_idx <= r_rcon_idx + 4'd1;
          if (r_rcon_idx == 4'd10) begin
            r_st        <= to_state(r_ct ^ w_rk_fwd);
            r_rk10_q    <= w_rk_fwd;
            r_key_q     <= r_key_in;
            r_cache_vld <= 1'b1;
            r_rnd       <= 4'd9;
            r_fsm       <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_rk <= w_rk_inv;
          r_st <= w_round_out;
          if (r_rnd == 4'd0) begin
            r_plain     <= from_state(w_round_out);
            r_out_valid <= 1'b1;
            r_fsm       <= ST_DONE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= ST_IDLE;
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.plain_text = r_plain;

endmodule

// File: tb/tb_aes128_ecb_decryptor_iter.sv
// Bench for the iterative AES-128 decryptor: FIPS vectors with latency, reset,
// back-pressure, and a random stream checked against a forward-cipher model.
module tb_aes128_ecb_decryptor_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes128_ecb_decryptor_iter_if bus_if ();

  aes128_ecb_decryptor_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           rx_count = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  bit           drv_done;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Forward AES-128 encryption, used to make ciphertexts for random plaintexts
  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, s, t;
    logic [31:0]  tw, w0, w1, w2, w3;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    s  = p ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tw = {sbox_t[rk[23:16]], sbox_t[rk[15:8]], sbox_t[rk[7:0]], sbox_t[rk[31:24]]} ^ {rc, 24'h000000};
      w0 = rk[127:96] ^ tw;
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[8 * (15 - (4 * c + rr)) +: 8] = sbox_t[s[8 * (15 - (4 * ((c + rr) % 4) + rr)) +: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[8 * (15 - 4 * c) +: 8];
          a1 = t[8 * (14 - 4 * c) +: 8];
          a2 = t[8 * (13 - 4 * c) +: 8];
          a3 = t[8 * (12 - 4 * c) +: 8];
          t[8 * (15 - 4 * c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[8 * (14 - 4 * c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[8 * (13 - 4 * c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[8 * (12 - 4 * c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p, output bit ok);
    int guard;
    guard = 0;
    while (bus_if.in_ready !== 1'b1 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, expected 1", bus_if.in_ready, guard);
      ok = 1'b0;
    end else begin
      bus_if.key         = k;
      bus_if.cipher_text = c;
      bus_if.in_valid    = 1'b1;
      exp_q.push_back(p);
      @(posedge clk); #1;
      bus_if.in_valid    = 1'b0;
      bus_if.key         = rand128();
      bus_if.cipher_text = rand128();
      ok = 1'b1;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Output scoreboard: the handshake completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got plain_text %h, expected no output", bus_if.plain_text);
      end else begin
        check("plain_text", bus_if.plain_text, exp_q.pop_front());
        rx_count++;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[5];
    int           lat;
    bit           ok;
    bit           quiet;
    logic [127:0] prev_key;

    vecs[0] = '{K_C1, CT_C1, PT_C1, 20};
    vecs[1] = '{K_C1, CT_C1, PT_C1, 10};
    vecs[2] = '{K_B,  CT_B,  PT_B,  20};
    vecs[3] = '{K_B,  CT_B,  PT_B,  10};
    vecs[4] = '{K_C1, CT_C1, PT_C1, 20};

    build_sbox();
    rst_n              = 1'b0;
    bus_if.in_valid    = 1'b0;
    bus_if.out_ready   = 1'b1;
    bus_if.key         = 128'd0;
    bus_if.cipher_text = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("reset_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("reset_plain_text", bus_if.plain_text, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS vectors: miss, hit, miss, hit, miss after a different key was cached
    foreach (vecs[i]) begin
      send(vecs[i].key, vecs[i].ct, vecs[i].pt, ok);
      wait_out(lat);
      check($sformatf("latency_vec%0d", i), 128'(lat), 128'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("idle_after_vec%0d", i), 128'(bus_if.in_ready), 128'd1);
    end

    // Reset in the middle of a cached-key decryption drops it and clears the cache
    send(K_C1, CT_C1, PT_C1, ok);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("midrun_reset_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("midrun_reset_plain_text", bus_if.plain_text, 128'd0);
    exp_q.delete();
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b0) quiet = 1'b0;
    end
    check("no_output_after_reset", 128'(quiet), 128'd1);
    send(K_C1, CT_C1, PT_C1, ok);
    wait_out(lat);
    check("latency_after_reset", 128'(lat), 128'd20);
    @(posedge clk); #1;

    // Back-pressure: result held, input side closed, in_valid pulses ignored
    bus_if.out_ready = 1'b0;
    send(K_B, CT_B, PT_B, ok);
    wait_out(lat);
    check("latency_hold", 128'(lat), 128'd20);
    for (int i = 0; i < 7; i++) begin
      bus_if.in_valid    = (i % 2 == 0);
      bus_if.key         = rand128();
      bus_if.cipher_text = rand128();
      @(posedge clk); #1;
      check("hold_plain_text", bus_if.plain_text, PT_B);
      check("hold_in_ready", 128'(bus_if.in_ready), 128'd0);
      check("hold_out_valid", 128'(bus_if.out_valid), 128'd1);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("release_in_ready", 128'(bus_if.in_ready), 128'd1);
    quiet = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b0) quiet = 1'b0;
    end
    check("ignored_pulses_no_output", 128'(quiet), 128'd1);

    // Random stream with output throttling and occasional key reuse
    rx_count = 0;
    drv_done = 1'b0;
    prev_key = K_B;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [127:0] k, p;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          k = ($urandom_range(0, 3) == 0) ? prev_key : rand128();
          p = rand128();
          prev_key = k;
          send(k, model_enc(k, p), p, ok);
          if (!ok) break;
        end
        drv_done = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while ((!drv_done || exp_q.size() != 0) && guard < 80000) begin
          @(posedge clk); #1;
          bus_if.out_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
        bus_if.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("stream_received", 128'(rx_count), 128'd1000);
    check("stream_pending", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
